// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Execute-stage bus between the pipeline and the multiply/
//                divide unit. The pipeline side (master) drives the command
//                and forwarded operands. The unit side (slave) returns the
//                busy flag and the HI/LO read data.
//  Signals     : start - launch the mult/div selected by sel
//                we    - mthi/mtlo write of a
//                sel   - 3-bit operation / register select
//                a, b  - forwarded rs / rt operands
//                busy  - operation in progress (to hazard unit)
//                c     - committed HI (sel[0]=0) or LO (sel[0]=1)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if;
    logic        start;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] c;

    modport master (
        output start, we, sel, a, b,
        input  busy, c
    );

    modport slave (
        input  start, we, sel, a, b,
        output busy, c
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Fixed-latency multiply/divide unit with architectural HI/LO.
//                A start computes the full result at once into a shadow pair.
//                It then counts down 5 (mult) or 10 (div) cycles and commits
//                the result into HI/LO as busy drops.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - mult_div_unit_if.slave (start/we/sel/a/b in,
//                       busy/c out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  wire logic           clk,
    input  wire logic           rst,
    mult_div_unit_if.slave      bus
);

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    localparam logic [2:0] SEL_MTHI = 3'b100;
    localparam logic [2:0] SEL_MTLO = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] rhi_q;
    logic [31:0] rlo_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        divz_q;     // pending result came from a divide by zero

    // ------------------------------------------------------------------
    // Result datapath (combinational, from this cycle's operands)
    // ------------------------------------------------------------------
    logic        w_op_valid;
    logic        w_is_signed;
    logic        w_is_div;
    logic        w_div_zero;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op_valid  = ~bus.sel[2];
    assign w_is_signed = ~bus.sel[0];
    assign w_is_div    = bus.sel[1];
    assign w_div_zero  = w_is_div & (bus.b == 32'd0);

    // One 64-bit multiplier serves both mult and multu. The operands are
    // sign- or zero-extended, and the low 64 bits of the product are exact.
    assign w_a_ext = {{32{w_is_signed & bus.a[31]}}, bus.a};
    assign w_b_ext = {{32{w_is_signed & bus.b[31]}}, bus.b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide is done on magnitudes and then the signs are fixed up.
    // This gives truncation toward zero with the remainder sign following
    // the dividend, and 0x80000000 / -1 needs no special case.
    assign w_a_neg    = w_is_signed & bus.a[31];
    assign w_b_neg    = w_is_signed & bus.b[31];
    assign w_dvd      = w_a_neg ? (32'd0 - bus.a) : bus.a;
    assign w_dvs      = w_b_neg ? (32'd0 - bus.b) : bus.b;
    // The divisor is forced to 1 on a zero divide only to keep the divider
    // defined. That result is never committed.
    assign w_dvs_safe = (bus.b == 32'd0) ? 32'd1 : w_dvs;
    assign w_quo_u    = w_dvd / w_dvs_safe;
    assign w_rem_u    = w_dvd % w_dvs_safe;
    assign w_quo      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo_u) : w_quo_u;
    assign w_rem      = w_a_neg ? (32'd0 - w_rem_u) : w_rem_u;

    assign w_res_hi = w_is_div ? w_rem : w_prod[63:32];
    assign w_res_lo = w_is_div ? w_quo : w_prod[31:0];

    // ------------------------------------------------------------------
    // Control FSM and architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            rhi_q   <= 32'd0;
            rlo_q   <= 32'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        // start has priority over we, even when it carries
                        // an unlisted sel code.
                        if (w_op_valid) begin
                            rhi_q   <= w_res_hi;
                            rlo_q   <= w_res_lo;
                            divz_q  <= w_div_zero;
                            cnt_q   <= w_is_div ? DIV_CYCLES : MUL_CYCLES;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end else if (bus.we) begin
                        if (bus.sel == SEL_MTHI) begin
                            hi_q <= bus.a;
                        end
                        if (bus.sel == SEL_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (!divz_q) begin
                            hi_q <= rhi_q;
                            lo_q <= rlo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    // Reads always see committed HI/LO. The shadow pair is never visible.
    assign bus.c    = bus.sel[0] ? lo_q : hi_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. It applies a table of
//                mult/div vectors with hand-computed HI/LO and busy lengths.
//                Hand-written sequences cover reset, write timing, divide by
//                zero, abort, contention and back-to-back starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic clk;
    logic rst;

    mult_div_unit_if mdu_if ();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (mdu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int n_cmp;
    int n_err;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        mdu_if.sel = 3'b110;
        #1 hi = mdu_if.c;
        mdu_if.sel = 3'b111;
        #1 lo = mdu_if.c;
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [31:0] val);
        mdu_if.sel = sel;
        mdu_if.a   = val;
        mdu_if.we  = 1'b1;
        tick();
        mdu_if.we  = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        mdu_if.sel   = sel;
        mdu_if.a     = a;
        mdu_if.b     = b;
        mdu_if.start = 1'b1;
        tick();
        mdu_if.start = 1'b0;
    endtask

    // Counts busy cycles starting from the current one. The bound keeps the
    // run finite if busy never drops.
    task automatic count_busy(output int n);
        n = 0;
        while (mdu_if.busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] hi, lo, hm, lm;
        int          n;

        n_cmp = 0;
        n_err = 0;

        //           sel     a             b             HI            LO            cycles
        vecs[0] = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[3] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[4] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5] = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[6] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};

        mdu_if.start = 1'b0;
        mdu_if.we    = 1'b0;
        mdu_if.sel   = 3'b110;
        mdu_if.a     = 32'd0;
        mdu_if.b     = 32'd0;
        rst          = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        read_hl(hi, lo);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, mdu_if.busy}, 32'd0);

        // mthi has no same-cycle bypass and becomes visible after the edge
        mdu_if.sel = 3'b100;
        mdu_if.a   = 32'h11112222;
        mdu_if.we  = 1'b1;
        #1 check("mthi_no_bypass", mdu_if.c, 32'd0);
        tick();
        mdu_if.we = 1'b0;
        read_hl(hi, lo);
        check("mthi_visible", hi, 32'h11112222);
        check("mthi_lo_kept", lo, 32'd0);

        // Table-driven vectors: preload markers to check that busy hides the result
        for (int i = 0; i < NVEC; i++) begin
            hm = 32'hC0DE0000 + i;
            lm = 32'hFACE0000 + i;
            write_reg(3'b100, hm);
            write_reg(3'b101, lm);
            start_op(vecs[i].sel, vecs[i].a, vecs[i].b);
            read_hl(hi, lo);
            check($sformatf("v%0d_old_hi_during_busy", i), hi, hm);
            check($sformatf("v%0d_old_lo_during_busy", i), lo, lm);
            count_busy(n);
            check($sformatf("v%0d_busy_cycles", i), n, vecs[i].cycles);
            read_hl(hi, lo);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // Divide by zero: ten busy cycles and HI/LO untouched
        write_reg(3'b100, 32'h12345678);
        write_reg(3'b101, 32'h9ABCDEF0);
        start_op(3'b011, 32'd7, 32'd0);
        count_busy(n);
        check("divz_busy_cycles", n, 10);
        read_hl(hi, lo);
        check("divz_hi", hi, 32'h12345678);
        check("divz_lo", lo, 32'h9ABCDEF0);

        // Abort: reset in busy cycle 3 clears busy and HI/LO, with no late commit
        start_op(3'b000, 32'd3, 32'd4);
        tick();
        tick();
        check("abort_busy_before", {31'd0, mdu_if.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy_after", {31'd0, mdu_if.busy}, 32'd0);
        for (int k = 0; k < 6; k++) tick();
        read_hl(hi, lo);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);

        // mtlo pulsed during busy is ignored
        write_reg(3'b100, 32'd1);
        write_reg(3'b101, 32'd2);
        start_op(3'b001, 32'd3, 32'd4);
        tick();
        write_reg(3'b101, 32'h000000AA);
        count_busy(n);
        check("we_busy_cycles", n, 3);
        read_hl(hi, lo);
        check("we_busy_hi", hi, 32'd0);
        check("we_busy_lo", lo, 32'd12);

        // start and we together: only the start takes effect
        write_reg(3'b101, 32'h55555555);
        mdu_if.sel   = 3'b000;
        mdu_if.a     = 32'd6;
        mdu_if.b     = 32'd7;
        mdu_if.start = 1'b1;
        mdu_if.we    = 1'b1;
        tick();
        mdu_if.start = 1'b0;
        mdu_if.we    = 1'b0;
        count_busy(n);
        check("startwe_busy_cycles", n, 5);
        read_hl(hi, lo);
        check("startwe_hi", hi, 32'd0);
        check("startwe_lo", lo, 32'd42);

        // Back-to-back: a second start in the first non-busy cycle is accepted
        start_op(3'b001, 32'd10, 32'd10);
        count_busy(n);
        start_op(3'b011, 32'd100, 32'd7);
        count_busy(n);
        check("b2b_busy_cycles", n, 10);
        read_hl(hi, lo);
        check("b2b_hi", hi, 32'd2);
        check("b2b_lo", lo, 32'd14);

        // start with a read-only sel code does nothing
        start_op(3'b110, 32'd9, 32'd9);
        check("badsel_busy", {31'd0, mdu_if.busy}, 32'd0);
        read_hl(hi, lo);
        check("badsel_lo", lo, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
